wb_regfile: RTL and testbench



---
 rtl/wb_regfile.sv | 111 +++++++++++
 tb/tb_wb_regfile.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// wb_regfile
//   Architectural integer register file (32 x 32-bit, x0 reads as zero) with
//   a per-register pending-write scoreboard used by ID for load-use stalls.
//
// Ports
//   clk, rst            : system clock, synchronous active-high reset
//   rdy                 : global ready; low freezes all state and the bypass
//   we, waddr, wdata    : write-back port from WB
//   re1, raddr1         : read port 1 request -> rdata1, pend1 (combinational)
//   re2, raddr2         : read port 2 request -> rdata2, pend2 (combinational)
//   set_pend, set_addr  : ID marks set_addr as having an outstanding producer
//   pend_cnt            : number of registers currently marked pending
module wb_regfile #(
   parameter int REG_NUM = 32,
   parameter int REG_W   = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rdy,
   input  logic             we,
   input  logic [4:0]       waddr,
   input  logic [REG_W-1:0] wdata,
   input  logic             re1,
   input  logic [4:0]       raddr1,
   output logic [REG_W-1:0] rdata1,
   output logic             pend1,
   input  logic             re2,
   input  logic [4:0]       raddr2,
   output logic [REG_W-1:0] rdata2,
   output logic             pend2,
   input  logic             set_pend,
   input  logic [4:0]       set_addr,
   output logic [5:0]       pend_cnt
);

   logic [REG_W-1:0]   regs_q [REG_NUM];
   logic [REG_W-1:0]   regs_d [REG_NUM];
   logic [REG_NUM-1:0] pend_q;
   logic [REG_NUM-1:0] pend_d;
   logic [5:0]         pend_cnt_q;
   logic [5:0]         pend_cnt_d;

   logic wr_en;
   logic hit1;
   logic hit2;

   assign wr_en = rdy && we && (waddr != 5'd0);
   assign hit1  = rdy && we && (waddr == raddr1);
   assign hit2  = rdy && we && (waddr == raddr2);

   always_comb begin
      regs_d = regs_q;
      pend_d = pend_q;
      if (wr_en) begin
         regs_d[waddr] = wdata;
         pend_d[waddr] = 1'b0;
      end
      // Applied after the clear: a new producer issued to the register being
      // written back must stay tracked, the write only retires the older one.
      if (rdy && set_pend && (set_addr != 5'd0)) begin
         pend_d[set_addr] = 1'b1;
      end
      regs_d[0] = '0;
      pend_d[0] = 1'b0;
   end

   // Counted from the next-state vector so pend_cnt tracks pend_q exactly.
   always_comb begin
      pend_cnt_d = '0;
      for (int i = 0; i < REG_NUM; i++) begin
         pend_cnt_d = pend_cnt_d + 6'(pend_d[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < REG_NUM; i++) begin
            regs_q[i] <= '0;
         end
         pend_q     <= '0;
         pend_cnt_q <= '0;
      end else begin
         regs_q     <= regs_d;
         pend_q     <= pend_d;
         pend_cnt_q <= pend_cnt_d;
      end
   end

   // Read ports: a same-cycle write-back is forwarded and also resolves the
   // hazard, so pend is suppressed whenever the bypass supplies the data.
   always_comb begin
      rdata1 = '0;
      pend1  = 1'b0;
      if (!rst && re1 && (raddr1 != 5'd0)) begin
         rdata1 = hit1 ? wdata : regs_q[raddr1];
         pend1  = pend_q[raddr1] && !hit1;
      end
   end

   always_comb begin
      rdata2 = '0;
      pend2  = 1'b0;
      if (!rst && re2 && (raddr2 != 5'd0)) begin
         rdata2 = hit2 ? wdata : regs_q[raddr2];
         pend2  = pend_q[raddr2] && !hit2;
      end
   end

   assign pend_cnt = pend_cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile
//   Directed stimulus for wb_regfile. A behavioural model (register array and
//   pending-bit array updated by the architectural rules) is checked against
//   every DUT output on each falling edge, and literal expectations pin the
//   model at the interesting points of each scenario.
module tb_wb_regfile;

   logic        clk;
   logic        rst;
   logic        rdy;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic        re1;
   logic [4:0]  raddr1;
   logic [31:0] rdata1;
   logic        pend1;
   logic        re2;
   logic [4:0]  raddr2;
   logic [31:0] rdata2;
   logic        pend2;
   logic        set_pend;
   logic [4:0]  set_addr;
   logic [5:0]  pend_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] m_reg  [32];
   bit          m_pend [32];
   bit          m_valid = 1'b0;

   wb_regfile #(.REG_NUM(32), .REG_W(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .rdy      (rdy),
      .we       (we),
      .waddr    (waddr),
      .wdata    (wdata),
      .re1      (re1),
      .raddr1   (raddr1),
      .rdata1   (rdata1),
      .pend1    (pend1),
      .re2      (re2),
      .raddr2   (raddr2),
      .rdata2   (rdata2),
      .pend2    (pend2),
      .set_pend (set_pend),
      .set_addr (set_addr),
      .pend_cnt (pend_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model state update at the active edge; inputs are stable here because
   // the stimulus changes them 1 time unit after each rising edge.
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            m_reg[i]  = 32'h0;
            m_pend[i] = 1'b0;
         end
         m_valid = 1'b1;
      end else if (rdy) begin
         if (set_pend && set_addr != 5'd0) begin
            // A second producer to a still-pending register is an ID bug,
            // unless this very edge retires the first one.
            chk("protocol_set_on_pending",
                32'(m_pend[set_addr] && !(we && waddr == set_addr)), 32'h0);
         end
         if (we && waddr != 5'd0) begin
            m_reg[waddr]  = wdata;
            m_pend[waddr] = 1'b0;
         end
         if (set_pend && set_addr != 5'd0) m_pend[set_addr] = 1'b1;
      end
   end

   function automatic logic [31:0] exp_rdata(input logic re, input logic [4:0] ra);
      if (rst || !re || ra == 5'd0) return 32'h0;
      if (rdy && we && waddr == ra) return wdata;
      return m_reg[ra];
   endfunction

   function automatic logic exp_pend(input logic re, input logic [4:0] ra);
      if (rst || !re || ra == 5'd0) return 1'b0;
      if (rdy && we && waddr == ra) return 1'b0;
      return m_pend[ra];
   endfunction

   always @(negedge clk) begin
      if (m_valid) begin
         int cnt;
         cnt = 0;
         for (int i = 0; i < 32; i++) cnt += int'(m_pend[i]);
         chk("model_rdata1", rdata1, exp_rdata(re1, raddr1));
         chk("model_rdata2", rdata2, exp_rdata(re2, raddr2));
         chk("model_pend1", 32'(pend1), 32'(exp_pend(re1, raddr1)));
         chk("model_pend2", 32'(pend2), 32'(exp_pend(re2, raddr2)));
         chk("model_pend_cnt", 32'(pend_cnt), 32'(cnt));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; rdy = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
      re1 = 1'b1; raddr1 = 5'd3; re2 = 1'b1; raddr2 = 5'd4;
      set_pend = 1'b1; set_addr = 5'd6;
      tick();
      tick();
      @(negedge clk);
      chk("rst_rdata1", rdata1, 32'h0);
      chk("rst_pend_cnt", 32'(pend_cnt), 32'h0);
      tick();
      rst = 1'b0; set_pend = 1'b0;

      // 1: everything reads zero after reset
      for (int i = 1; i < 32; i++) begin
         raddr1 = 5'(i);
         raddr2 = 5'(32 - i);
         @(negedge clk);
         chk("t1_rdata1", rdata1, 32'h0);
         chk("t1_rdata2", rdata2, 32'h0);
         chk("t1_pend1", 32'(pend1), 32'h0);
         tick();
      end

      // 2: bypass, then storage
      we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; raddr1 = 5'd5;
      @(negedge clk);
      chk("t2_bypass", rdata1, 32'hDEADBEEF);
      tick();
      we = 1'b0;
      @(negedge clk);
      chk("t2_stored", rdata1, 32'hDEADBEEF);
      tick();

      // 3: x0 writes discarded
      we = 1'b1; waddr = 5'd0; wdata = 32'h12345678; raddr1 = 5'd0; raddr2 = 5'd0;
      @(negedge clk);
      chk("t3_x0_rd1_pre", rdata1, 32'h0);
      chk("t3_x0_rd2_pre", rdata2, 32'h0);
      tick();
      we = 1'b0;
      @(negedge clk);
      chk("t3_x0_rd1_post", rdata1, 32'h0);
      chk("t3_x0_rd2_post", rdata2, 32'h0);
      tick();

      // 4: set pending, clear with same-cycle resolution
      set_pend = 1'b1; set_addr = 5'd7;
      tick();
      set_pend = 1'b0; raddr2 = 5'd7;
      @(negedge clk);
      chk("t4_pend2_set", 32'(pend2), 32'h1);
      chk("t4_cnt_one", 32'(pend_cnt), 32'h1);
      tick();
      we = 1'b1; waddr = 5'd7; wdata = 32'h55;
      @(negedge clk);
      chk("t4_pend2_resolved", 32'(pend2), 32'h0);
      chk("t4_rdata2_bypass", rdata2, 32'h55);
      chk("t4_cnt_still_one", 32'(pend_cnt), 32'h1);
      tick();
      we = 1'b0;
      @(negedge clk);
      chk("t4_cnt_zero", 32'(pend_cnt), 32'h0);
      chk("t4_rdata2_stored", rdata2, 32'h55);
      tick();

      // 5: set wins over clear on the same register
      set_pend = 1'b1; set_addr = 5'd9;
      tick();
      set_pend = 1'b0;
      @(negedge clk);
      chk("t5_cnt_one", 32'(pend_cnt), 32'h1);
      tick();
      we = 1'b1; waddr = 5'd9; wdata = 32'h99; set_pend = 1'b1; set_addr = 5'd9;
      raddr1 = 5'd9;
      @(negedge clk);
      chk("t5_pend1_bypass", 32'(pend1), 32'h0);
      chk("t5_rdata1_bypass", rdata1, 32'h99);
      tick();
      we = 1'b0; set_pend = 1'b0;
      @(negedge clk);
      chk("t5_pend1_kept", 32'(pend1), 32'h1);
      chk("t5_rdata1_stored", rdata1, 32'h99);
      chk("t5_cnt_unchanged", 32'(pend_cnt), 32'h1);
      tick();

      // Fill registers with a pattern; port 2 reads the previous one
      for (int i = 1; i < 32; i++) begin
         if (i == 3 || i == 4 || i == 9) continue;
         we = 1'b1; waddr = 5'(i); wdata = (32'(i) * 32'h01010101) ^ 32'hA5A5A5A5;
         raddr1 = 5'(i); raddr2 = 5'(i - 1);
         tick();
      end
      we = 1'b0;
      raddr1 = 5'd17; raddr2 = 5'd31;
      @(negedge clk);
      chk("fill_r17", rdata1, 32'hB4B4B4B4);
      chk("fill_r31", rdata2, 32'hBABABABA);
      tick();

      // 6: rdy low freezes everything and disables the bypass
      rdy = 1'b0; we = 1'b1; waddr = 5'd3; wdata = 32'hAA;
      set_pend = 1'b1; set_addr = 5'd4; raddr1 = 5'd3; raddr2 = 5'd4;
      @(negedge clk);
      chk("t6_no_bypass", rdata1, 32'h0);
      chk("t6_pend2_pre", 32'(pend2), 32'h0);
      tick();
      @(negedge clk);
      chk("t6_reg3_frozen", rdata1, 32'h0);
      chk("t6_pend4_frozen", 32'(pend2), 32'h0);
      chk("t6_cnt_frozen", 32'(pend_cnt), 32'h1);
      tick();
      rdy = 1'b1; we = 1'b0; set_pend = 1'b0;
      @(negedge clk);
      chk("t6_reg3_after", rdata1, 32'h0);
      tick();
      set_pend = 1'b1; set_addr = 5'd4;
      tick();
      set_pend = 1'b0;
      @(negedge clk);
      chk("t6_cnt_two", 32'(pend_cnt), 32'h2);
      chk("t6_pend2_set", 32'(pend2), 32'h1);
      tick();

      // Reset mid-operation
      rst = 1'b1; raddr1 = 5'd9; we = 1'b1; waddr = 5'd9; wdata = 32'h77;
      @(negedge clk);
      chk("rst_mid_rdata1", rdata1, 32'h0);
      chk("rst_mid_pend2", 32'(pend2), 32'h0);
      tick();
      rst = 1'b0; we = 1'b0;
      @(negedge clk);
      chk("rst_mid_cnt", 32'(pend_cnt), 32'h0);
      chk("rst_mid_reg9", rdata1, 32'h0);
      chk("rst_mid_pend4", 32'(pend2), 32'h0);
      tick();

      // set_pend to x0 is ignored
      set_pend = 1'b1; set_addr = 5'd0;
      tick();
      set_pend = 1'b0;
      @(negedge clk);
      chk("x0_set_ignored", 32'(pend_cnt), 32'h0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
